// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver and instruction-memory programmer.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 8;

    // Integer-truncated clocks per oversample tick.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversample tick generator and framing FSM.
import uart_pkg::*;

module uart_rx #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       Rst_n,
    input  logic       rx,
    input  logic       prog,
    output logic       byte_vld,
    output logic       stop_err,
    output logic [7:0] rx_byte
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);
    localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;

    generate
        if (DIV < 1) begin : g_div_chk
            $error("uart_rx: CLK_FREQ too low for BAUD, divider would be zero");
        end
    endgenerate

    logic [1:0]    sync;
    logic          rx_s;
    rx_state_t     state, state_n;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    smp_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    assign rx_s    = sync[1];
    assign tick    = (state != IDLE) && (tick_cnt == TW'(DIV - 1));
    assign rx_byte = shreg;

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            sync     <= 2'b11;
            state    <= IDLE;
            tick_cnt <= '0;
            smp_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            sync  <= {sync[0], rx};
            state <= state_n;

            if (state == IDLE || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + TW'(1);

            // Sample counter restarts on every state change; in DATA it wraps every 16 ticks.
            if (state_n != state)
                smp_cnt <= '0;
            else if (tick)
                smp_cnt <= smp_cnt + 4'd1;

            if (state == DATA && tick && smp_cnt == 4'(OVERSAMPLE - 1)) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end else if (state != DATA) begin
                bit_idx <= '0;
            end
        end
    end

    always_comb begin
        state_n  = state;
        byte_vld = 1'b0;
        stop_err = 1'b0;
        case (state)
            IDLE: begin
                if (prog && !rx_s)
                    state_n = START;
            end
            START: begin
                if (tick && smp_cnt == 4'(MID_SAMPLE - 1))
                    state_n = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (tick && smp_cnt == 4'(OVERSAMPLE - 1) && bit_idx == 3'd7)
                    state_n = STOP;
            end
            STOP: begin
                if (tick && smp_cnt == 4'(OVERSAMPLE - 1)) begin
                    state_n  = IDLE;
                    byte_vld = rx_s;
                    stop_err = !rx_s;
                end
            end
            default: state_n = IDLE;
        endcase
        // Leaving programming mode aborts any frame in flight, including its completion.
        if (!prog) begin
            state_n  = IDLE;
            byte_vld = 1'b0;
            stop_err = 1'b0;
        end
    end

endmodule

// File: rtl/uart_imem_programmer.sv
// Serial instruction-memory loader: assembles UART bytes little-endian into words with an auto-incrementing address.
import uart_pkg::*;

module uart_imem_programmer #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115_200,
    parameter int unsigned ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              Rst_n,
    input  logic              rx,
    input  logic              prog,
    output logic              memcon_prog_ena,
    output logic [31:0]       uart_dout,
    output logic [ADDR_W-1:0] prog_addr,
    output logic              prog_wea,
    output logic              frame_err,
    output logic [ADDR_W-3:0] word_cnt
);

    logic        byte_vld;
    logic        stop_err;
    logic [7:0]  rx_byte;
    logic [1:0]  bidx;
    logic [23:0] shadow;
    logic        prog_rise;

    uart_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) u_rx (
        .clk     (clk),
        .Rst_n   (Rst_n),
        .rx      (rx),
        .prog    (prog),
        .byte_vld(byte_vld),
        .stop_err(stop_err),
        .rx_byte (rx_byte)
    );

    assign prog_rise = prog && !memcon_prog_ena;

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            memcon_prog_ena <= 1'b0;
            uart_dout       <= '0;
            prog_addr       <= '0;
            prog_wea        <= 1'b0;
            frame_err       <= 1'b0;
            word_cnt        <= '0;
            bidx            <= '0;
            shadow          <= '0;
        end else begin
            memcon_prog_ena <= prog;
            prog_wea        <= 1'b0;

            if (prog_wea) begin
                prog_addr <= prog_addr + ADDR_W'(4);
                word_cnt  <= word_cnt + (ADDR_W-2)'(1);
            end

            // Lower bytes are staged in a shadow so uart_dout only changes at a strobe.
            if (!prog) begin
                bidx      <= '0;
                prog_addr <= '0;
            end else if (byte_vld) begin
                bidx   <= bidx + 2'd1;
                shadow <= {rx_byte, shadow[23:8]};
                if (bidx == 2'd3) begin
                    uart_dout <= {rx_byte, shadow};
                    prog_wea  <= 1'b1;
                end
            end

            if (prog_rise) begin
                word_cnt  <= '0;
                frame_err <= 1'b0;
            end else if (stop_err) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_imem_programmer.sv
// Directed self-checking bench for uart_imem_programmer (16 clocks per bit).
import uart_pkg::*;

module tb_uart_imem_programmer;

  logic        clk;
  logic        Rst_n;
  logic        rx;
  logic        prog;

  logic        ena_a, wea_a, ferr_a;
  logic [31:0] dout_a;
  logic [11:0] addr_a;
  logic [9:0]  wcnt_a;

  logic        ena_b, wea_b, ferr_b;
  logic [31:0] dout_b;
  logic [3:0]  addr_b;
  logic [1:0]  wcnt_b;

  int checks   = 0;
  int failures = 0;
  logic done   = 1'b0;

  int          n_a = 0;
  int          n_b = 0;
  int          bv_cnt = 0;
  logic [31:0] sa_data [32];
  logic [11:0] sa_addr [32];
  logic [3:0]  sb_addr [32];

  int base;
  int bv0;

  uart_imem_programmer #(
    .CLK_FREQ(1_600_000),
    .BAUD    (100_000),
    .ADDR_W  (12)
  ) dut (
    .clk            (clk),
    .Rst_n          (Rst_n),
    .rx             (rx),
    .prog           (prog),
    .memcon_prog_ena(ena_a),
    .uart_dout      (dout_a),
    .prog_addr      (addr_a),
    .prog_wea       (wea_a),
    .frame_err      (ferr_a),
    .word_cnt       (wcnt_a)
  );

  uart_imem_programmer #(
    .CLK_FREQ(1_600_000),
    .BAUD    (100_000),
    .ADDR_W  (4)
  ) dut4 (
    .clk            (clk),
    .Rst_n          (Rst_n),
    .rx             (rx),
    .prog           (prog),
    .memcon_prog_ena(ena_b),
    .uart_dout      (dout_b),
    .prog_addr      (addr_b),
    .prog_wea       (wea_b),
    .frame_err      (ferr_b),
    .word_cnt       (wcnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL timeout: stimulus did not complete within 200000 cycles");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  always @(negedge clk) begin
    if (wea_a) begin
      check("wea_a_owned", 32'(ena_a), 32'd1);
      if (n_a < 32) begin
        sa_data[n_a] = dout_a;
        sa_addr[n_a] = addr_a;
      end
      n_a++;
    end
    if (wea_b) begin
      check("wea_b_owned", 32'(ena_b), 32'd1);
      if (n_b < 32) sb_addr[n_b] = addr_b;
      n_b++;
    end
    if (dut.u_rx.byte_vld) bv_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int unsigned i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop_bit;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0], 1'b1);
    send_byte(w[15:8], 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[31:24], 1'b1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rx    = 1'b1;
    prog  = 1'b0;
    Rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_ena", 32'(ena_a), 32'd0);
    check("rst_dout", dout_a, 32'h0);
    check("rst_addr", 32'(addr_a), 32'h0);
    check("rst_wea", 32'(wea_a), 32'd0);
    check("rst_ferr", 32'(ferr_a), 32'd0);
    check("rst_wcnt", 32'(wcnt_a), 32'd0);

    Rst_n = 1'b1;
    prog  = 1'b1;
    @(negedge clk);
    check("ena_rise_lag", 32'(ena_a), 32'd1);
    repeat (4) @(negedge clk);

    send_word(32'h00A0_0513);
    check("basic_nstrobe", n_a, 32'd1);
    check("basic_data", sa_data[0], 32'h00A0_0513);
    check("basic_addr", 32'(sa_addr[0]), 32'h000);
    check("basic_wcnt", 32'(wcnt_a), 32'd1);
    check("basic_addr_next", 32'(addr_a), 32'h004);
    check("basic_dout_hold", dout_a, 32'h00A0_0513);

    prog = 1'b0;
    repeat (3) @(negedge clk);
    prog = 1'b1;
    repeat (3) @(negedge clk);
    check("rise_wcnt_clr", 32'(wcnt_a), 32'd0);
    check("fall_addr_clr", 32'(addr_a), 32'h000);
    send_word(32'h1122_3344);
    send_word(32'hDEAD_BEEF);
    send_word(32'h0000_0093);
    check("consec_nstrobe", n_a, 32'd4);
    check("consec_d0", sa_data[1], 32'h1122_3344);
    check("consec_a0", 32'(sa_addr[1]), 32'h000);
    check("consec_d1", sa_data[2], 32'hDEAD_BEEF);
    check("consec_a1", 32'(sa_addr[2]), 32'h004);
    check("consec_d2", sa_data[3], 32'h0000_0093);
    check("consec_a2", 32'(sa_addr[3]), 32'h008);
    check("consec_wcnt", 32'(wcnt_a), 32'd3);
    check("consec_ferr", 32'(ferr_a), 32'd0);

    bv0 = bv_cnt;
    send_byte(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_set", 32'(ferr_a), 32'd1);
    check("ferr_no_bv", bv_cnt, bv0);
    check("ferr_bidx", 32'(dut.bidx), 32'd0);
    send_word(32'h1234_5678);
    check("ferr_nstrobe", n_a, 32'd5);
    check("ferr_word", sa_data[4], 32'h1234_5678);
    check("ferr_addr", 32'(sa_addr[4]), 32'h00C);
    check("ferr_sticky", 32'(ferr_a), 32'd1);

    bv0 = bv_cnt;
    rx  = 1'b0;
    repeat (4) @(negedge clk);
    rx  = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_no_bv", bv_cnt, bv0);
    check("glitch_idle", 32'(dut.u_rx.state), 32'(IDLE));
    check("glitch_nstrobe", n_a, 32'd5);

    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    prog = 1'b0;
    @(negedge clk);
    check("abort_ena", 32'(ena_a), 32'd0);
    check("abort_addr", 32'(addr_a), 32'h000);
    check("abort_bidx", 32'(dut.bidx), 32'd0);
    check("abort_wcnt_kept", 32'(wcnt_a), 32'd4);
    check("abort_ferr_kept", 32'(ferr_a), 32'd1);
    check("abort_dout_kept", dout_a, 32'h1234_5678);
    repeat (10) @(negedge clk);
    check("abort_nstrobe", n_a, 32'd5);
    prog = 1'b1;
    repeat (3) @(negedge clk);
    check("rerise_wcnt", 32'(wcnt_a), 32'd0);
    check("rerise_ferr", 32'(ferr_a), 32'd0);
    send_word(32'hCAFE_F00D);
    check("rerise_nstrobe", n_a, 32'd6);
    check("rerise_data", sa_data[5], 32'hCAFE_F00D);
    check("rerise_addr", 32'(sa_addr[5]), 32'h000);

    Rst_n = 1'b0;
    repeat (2) @(negedge clk);
    Rst_n = 1'b1;
    repeat (4) @(negedge clk);
    base = n_b;
    send_word(32'h0000_0001);
    send_word(32'h0000_0002);
    send_word(32'h0000_0003);
    send_word(32'h0000_0004);
    send_word(32'hA5A5_5A5A);
    check("wrap_nstrobe", n_b - base, 32'd5);
    check("wrap_a3", 32'(sb_addr[base + 3]), 32'hC);
    check("wrap_a4", 32'(sb_addr[base + 4]), 32'h0);
    check("wrap_wcnt", 32'(wcnt_b), 32'd1);
    check("wrap_addr_next", 32'(addr_b), 32'h4);
    check("wrap_dout", dout_b, 32'hA5A5_5A5A);

    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    Rst_n = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    check("midrst_ena", 32'(ena_b), 32'd0);
    check("midrst_dout", dout_b, 32'h0);
    check("midrst_addr", 32'(addr_b), 32'h0);
    check("midrst_wea", 32'(wea_b), 32'd0);
    check("midrst_ferr", 32'(ferr_b), 32'd0);
    check("midrst_wcnt", 32'(wcnt_b), 32'd0);
    check("midrst_state", 32'(dut.u_rx.state), 32'(IDLE));
    Rst_n = 1'b1;
    repeat (20) @(negedge clk);
    base = n_a;
    send_word(32'h0BAD_C0DE);
    check("postrst_nstrobe", n_a - base, 32'd1);
    check("postrst_data", sa_data[base], 32'h0BAD_C0DE);
    check("postrst_addr", 32'(sa_addr[base]), 32'h000);

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
